// File: rtl/mips32_pkg.sv
// mips32_pkg: shared MIPS32 constants, instruction-memory state enum and address helper
package mips32_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic {CLEAR, RUN} imem_state_e;
  function automatic logic [31:0] word_off(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction
endpackage

// File: rtl/instr_mem_sync_if.sv
// instr_mem_sync_if: fetch, program-load and status signals of the instruction memory
interface instr_mem_sync_if;
  logic        FetchReq;
  logic [31:0] Address;
  logic        Stall;
  logic        ProgWe;
  logic [31:0] ProgAddr;
  logic [31:0] ProgData;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        Fault;
  logic        MemReady;
  modport master (
    output FetchReq, Address, Stall, ProgWe, ProgAddr, ProgData,
    input  Instruction, InstrValid, Fault, MemReady
  );
  modport slave (
    input  FetchReq, Address, Stall, ProgWe, ProgAddr, ProgData,
    output Instruction, InstrValid, Fault, MemReady
  );
endinterface

// File: rtl/imem_ram_1r1w.sv
// imem_ram_1r1w: storage array with one synchronous write port and one enabled synchronous read port
module imem_ram_1r1w
  import mips32_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = INSTR_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  // write port and read register; the read register holds its value when re is low
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: instruction memory with NOP clear after reset, program-load port and 1-cycle fetch
module instr_mem_sync
  import mips32_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] NOP_WORD  = NOP_INSTR
) (
  input logic             Clk,
  input logic             Reset_n,
  instr_mem_sync_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  imem_state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic valid_q, valid_d, fault_q, fault_d, use_ram_q, use_ram_d;
  logic [INSTR_W-1:0] byp_q, byp_d;
  logic [31:0] f_off, p_off;
  logic fetch_ok, prog_ok, run, accept, bypass, ram_we, ram_re;
  logic [AW-1:0] fetch_idx, prog_idx, ram_waddr;
  logic [INSTR_W-1:0] ram_wdata, ram_rdata;
  assign f_off     = word_off(bus.Address, BASE_ADDR);
  assign p_off     = word_off(bus.ProgAddr, BASE_ADDR);
  assign fetch_ok  = bus.Address[1:0] == 2'b00 && f_off < 32'(DEPTH);
  assign prog_ok   = bus.ProgAddr[1:0] == 2'b00 && p_off < 32'(DEPTH);
  assign fetch_idx = f_off[AW-1:0];
  assign prog_idx  = p_off[AW-1:0];
  // state register, clear index and response registers; the storage array itself is never reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= CLEAR;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      use_ram_q <= 1'b0;
      byp_q     <= NOP_WORD;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      use_ram_q <= use_ram_d;
      byp_q     <= byp_d;
    end
  end
  // next state: sweep every word once in CLEAR, then stay in RUN until reset
  always_comb begin
    state_d = (state_q == CLEAR && idx_q == LAST) ? RUN : state_q;
    idx_d   = (state_q == CLEAR) ? idx_q + 1'b1 : idx_q;
  end
  // FSM outputs: the write port belongs to the clear sweep in CLEAR and to the program port in RUN
  always_comb begin
    run       = state_q == RUN;
    ram_we    = !run || (bus.ProgWe && prog_ok);
    ram_waddr = run ? prog_idx : idx_q;
    ram_wdata = run ? bus.ProgData : NOP_WORD;
  end
  // fetch response: a same-word write or a fault is answered from byp_q, otherwise from the RAM read register
  always_comb begin
    accept    = run && bus.FetchReq && !bus.Stall;
    bypass    = bus.ProgWe && prog_ok && fetch_ok && prog_idx == fetch_idx;
    ram_re    = accept && fetch_ok && !bypass;
    valid_d   = bus.Stall ? valid_q : accept;
    fault_d   = bus.Stall ? fault_q : accept && !fetch_ok;
    use_ram_d = accept ? ram_re : use_ram_q;
    byp_d     = (accept && !ram_re) ? (fetch_ok ? bus.ProgData : NOP_WORD) : byp_q;
  end
  imem_ram_1r1w #(.DEPTH(DEPTH), .WIDTH(INSTR_W)) u_ram (
    .clk  (Clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(fetch_idx),
    .rdata(ram_rdata)
  );
  assign bus.Instruction = use_ram_q ? ram_rdata : byp_q;
  assign bus.InstrValid  = valid_q;
  assign bus.Fault       = fault_q;
  assign bus.MemReady    = run;
endmodule
